// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the weight/input memory load enables and MAC gating of one MAC row.
// Each group: weight settle, K_LEN-word input stream, issue-pipe drain, result handshake.
module systolic_seq_ctrl #(
  parameter int unsigned K_LEN    = 16,
  parameter int unsigned N_GROUPS = 4,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned GRP_W    = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             grp_ready,
  output logic             busy,
  output logic             w_load_en,
  output logic             in_load_en,
  output logic             acc_clr,
  output logic             mac_en,
  output logic             grp_valid,
  output logic [GRP_W-1:0] grp_idx,
  output logic             done
);

  localparam int unsigned      MAX_LEN       = (K_LEN > RD_LAT) ? K_LEN : RD_LAT;
  localparam int unsigned      CNT_W         = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] K_LAST        = CNT_W'(K_LEN - 1);
  localparam logic [CNT_W-1:0] R_LAST        = CNT_W'(RD_LAT - 1);
  localparam logic [GRP_W-1:0] G_LAST        = GRP_W'(N_GROUPS - 1);
  localparam logic             ACC_CLR_FIRST = (RD_LAT == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WFILL  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_NEXT   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [RD_LAT-1:0] issue_sr;

  assign cnt_inc   = cnt + CNT_W'(1);
  assign mac_en    = issue_sr[RD_LAT-1];
  assign w_load_en = grp_valid & grp_ready;

  // Phase sequencing; outputs are loaded with the value of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      grp_idx    <= '0;
      busy       <= 1'b0;
      in_load_en <= 1'b0;
      acc_clr    <= 1'b0;
      grp_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_WFILL;
            cnt     <= '0;
            grp_idx <= '0;
            busy    <= 1'b1;
            acc_clr <= ACC_CLR_FIRST;
          end
        end
        S_WFILL: begin
          if (cnt == R_LAST) begin
            state      <= S_STREAM;
            cnt        <= '0;
            acc_clr    <= 1'b0;
            in_load_en <= 1'b1;
          end else begin
            cnt     <= cnt_inc;
            acc_clr <= (cnt_inc == R_LAST);
          end
        end
        S_STREAM: begin
          if (cnt == K_LAST) begin
            state      <= S_DRAIN;
            cnt        <= '0;
            in_load_en <= 1'b0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_DRAIN: begin
          if (cnt == R_LAST) begin
            state     <= S_NEXT;
            cnt       <= '0;
            grp_valid <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_NEXT: begin
          // Hold the result and the group index until downstream takes it.
          if (grp_ready) begin
            grp_valid <= 1'b0;
            cnt       <= '0;
            if (grp_idx == G_LAST) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state   <= S_WFILL;
              grp_idx <= grp_idx + GRP_W'(1);
              acc_clr <= ACC_CLR_FIRST;
            end
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
          grp_idx <= '0;
        end
        default: begin
          state      <= S_IDLE;
          cnt        <= '0;
          grp_idx    <= '0;
          busy       <= 1'b0;
          in_load_en <= 1'b0;
          acc_clr    <= 1'b0;
          grp_valid  <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

  // Issue pipe: one bit per STREAM cycle, emerging as mac_en when the read data lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_sr <= '0;
    end else begin
      for (int i = int'(RD_LAT) - 1; i > 0; i--) begin
        issue_sr[i] <= issue_sr[i-1];
      end
      issue_sr[0] <= in_load_en;
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: default-parameter instance plus a K_LEN=N_GROUPS=RD_LAT=1 instance,
// both compared every cycle against a timing-table model, with literal cycle checks on top.
module tb_systolic_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, ready_a = 1'b1, start_b = 1'b0, ready_b = 1'b1;
  logic busy_a, wl_a, il_a, ac_a, me_a, gv_a, dn_a;
  logic busy_b, wl_b, il_b, ac_b, me_b, gv_b, dn_b;
  logic [1:0] gi_a;
  logic [0:0] gi_b;

  always #5 clk = ~clk;

  systolic_seq_ctrl #(.K_LEN(16), .N_GROUPS(4), .RD_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .grp_ready(ready_a),
    .busy(busy_a), .w_load_en(wl_a), .in_load_en(il_a), .acc_clr(ac_a),
    .mac_en(me_a), .grp_valid(gv_a), .grp_idx(gi_a), .done(dn_a));

  systolic_seq_ctrl #(.K_LEN(1), .N_GROUPS(1), .RD_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .grp_ready(ready_b),
    .busy(busy_b), .w_load_en(wl_b), .in_load_en(il_b), .acc_clr(ac_b),
    .mac_en(me_b), .grp_valid(gv_b), .grp_idx(gi_b), .done(dn_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position t inside the group period (t=1 is the first weight-settle cycle).
  typedef struct { bit active; bit fin; int grp; int t; } mdl_t;
  mdl_t ma = '{default: 0};
  mdl_t mb = '{default: 0};

  function automatic mdl_t mstep(mdl_t m, logic st, logic rdy, int k, int n, int r);
    mdl_t x = m;
    if (m.fin) begin
      x = '{default: 0};
    end else if (!m.active) begin
      if (st) begin x.active = 1'b1; x.t = 1; x.grp = 0; end
    end else if (m.t < 2*r + k + 1) begin
      x.t = m.t + 1;
    end else if (rdy) begin
      if (m.grp == n - 1) begin x.fin = 1'b1; x.t = 0; end
      else begin x.grp = m.grp + 1; x.t = 1; end
    end
    return x;
  endfunction

  // {busy, w_load_en, in_load_en, acc_clr, mac_en, grp_valid, done}
  function automatic logic [6:0] mexp(mdl_t m, logic rdy, int k, int r);
    logic v;
    v = m.active && !m.fin && (m.t >= 2*r + k + 1);
    return {m.active, v && rdy, (m.t >= r + 1) && (m.t <= r + k), (m.t == r),
            (m.t >= 2*r + 1) && (m.t <= 2*r + k), v, m.fin};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{default: 0};
      mb <= '{default: 0};
    end else begin
      ma <= mstep(ma, start_a, ready_a, 16, 4, 2);
      mb <= mstep(mb, start_b, ready_b, 1, 1, 1);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("outs_a", 32'({busy_a, wl_a, il_a, ac_a, me_a, gv_a, dn_a}), 32'(mexp(ma, ready_a, 16, 2)));
    check("gidx_a", 32'(gi_a), ma.grp);
    check("outs_b", 32'({busy_b, wl_b, il_b, ac_b, me_b, gv_b, dn_b}), 32'(mexp(mb, ready_b, 1, 1)));
    check("gidx_b", 32'(gi_b), mb.grp);
  end

  int r_done, r_mac1, r_in, r_w, r_mac, r_stall;
  int r_gv[$];
  int r_gi[$];

  // One run, cycle 0 = the cycle in which start is sampled; optional backpressure on one group.
  task automatic run(input bit sel, input int bp_grp, input int bp_len, input bit keep);
    logic me, il, wl, gv, dn;
    int gi;
    bit fin;
    fin = 1'b0;
    r_done = -1; r_mac1 = -1; r_in = 0; r_w = 0; r_mac = 0; r_stall = 0;
    r_gv.delete(); r_gi.delete();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    for (int k = 0; k < 400 && !fin; k++) begin
      @(negedge clk);
      if (sel) begin me = me_b; il = il_b; wl = wl_b; gv = gv_b; dn = dn_b; gi = int'(gi_b); end
      else     begin me = me_a; il = il_a; wl = wl_a; gv = gv_a; dn = dn_a; gi = int'(gi_a); end
      if (me && r_mac1 < 0) r_mac1 = k;
      if (me) r_mac++;
      if (il) r_in++;
      if (wl) r_w++;
      if (gv && wl) begin r_gv.push_back(k); r_gi.push_back(gi); end
      if (dn) begin r_done = k; fin = 1'b1; end
      if (!sel && gv && !ready_a) r_stall++;
      @(posedge clk); #1;
      if (!keep) begin start_a = 1'b0; start_b = 1'b0; end
      if (!sel && bp_len > 0) ready_a = !(gi == bp_grp && r_stall < bp_len);
    end
    ready_a = 1'b1;
    if (!fin) check("run_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_a", 32'({busy_a, wl_a, il_a, ac_a, me_a, gv_a, dn_a, gi_a}), 32'd0);
    check("reset_outs_b", 32'({busy_b, wl_b, il_b, ac_b, me_b, gv_b, dn_b, gi_b}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold_a", 32'({busy_a, wl_a, il_a, ac_a, me_a, gv_a, dn_a, gi_a}), 32'd0);

    // Single default run
    run(1'b0, 0, 0, 1'b0);
    check("done_cyc", r_done, 32'd85);
    check("mac_first", r_mac1, 32'd5);
    check("in_cnt", r_in, 32'd64);
    check("mac_cnt", r_mac, 32'd64);
    check("wload_cnt", r_w, 32'd4);
    check("gv_count", r_gv.size(), 32'd4);
    for (int i = 0; i < r_gv.size() && i < 4; i++) begin
      check("gv_cyc", r_gv[i], 21 * (i + 1));
      check("gv_idx", r_gi[i], i);
    end
    repeat (3) @(posedge clk);
    #1;

    // Backpressure on group 1 for 5 cycles
    run(1'b0, 1, 5, 1'b0);
    check("bp_done_cyc", r_done, 32'd90);
    check("bp_stall", r_stall, 32'd5);
    check("bp_wload_cnt", r_w, 32'd4);
    check("bp_in_cnt", r_in, 32'd64);
    if (r_gv.size() > 1) check("bp_gv1_cyc", r_gv[1], 32'd47);
    repeat (2) @(posedge clk);
    #1;

    // start held high: one run per IDLE visit, second run starts at cycle 86
    run(1'b0, 0, 0, 1'b1);
    check("held_done_cyc", r_done, 32'd85);
    cnt = r_in;
    check("held_in_ptr", cnt, 32'd64);
    run(1'b0, 0, 0, 1'b0);
    check("rerun_mac_first", r_mac1, 32'd5);
    check("rerun_done_cyc", r_done, 32'd85);
    check("rerun_in_ptr", cnt + r_in, 32'd128);
    repeat (2) @(posedge clk);
    #1;

    // Reset at the 7th STREAM cycle of group 2
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("pre_rst_stream", 32'({il_a, gi_a}), 32'b110);
    rst_n = 1'b0;
    #1;
    check("rst_imm_a", 32'({busy_a, wl_a, il_a, ac_a, me_a, gv_a, dn_a, gi_a}), 32'd0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (wl_a || il_a) cnt++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    if (wl_a || il_a) cnt++;
    check("rst_no_load", cnt, 32'd0);
    @(posedge clk); #1;
    run(1'b0, 0, 0, 1'b0);
    if (r_gi.size() > 0) check("restart_idx0", r_gi[0], 32'd0);
    check("restart_done", r_done, 32'd85);

    // Minimal parameters on the second instance
    run(1'b1, 0, 0, 1'b0);
    check("edge_done_cyc", r_done, 32'd5);
    check("edge_mac_first", r_mac1, 32'd3);
    check("edge_in_cnt", r_in, 32'd1);
    check("edge_mac_cnt", r_mac, 32'd1);
    check("edge_wload_cnt", r_w, 32'd1);
    if (r_gv.size() > 0) check("edge_gv_cyc", r_gv[0], 32'd4);
    else check("edge_gv_seen", 32'd0, 32'd1);
    repeat (3) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencer for the weight and input memory interfaces feeding the N_MACS-wide MAC row. On `start`, it runs N_GROUPS output groups. For each group it:
- holds one weight line stable,
- streams K_LEN input words through the input memory interface,
- gates the MAC accumulators with `acc_clr` and `mac_en`, aligned to the 2-register read pipeline of the memory interfaces,
- presents a group-result handshake downstream.

It sits between top-level control and the `load_en` pins of the two memory interfaces.

## Interface
- `K_LEN`, 16: input words accumulated per group (≥1).
- `N_GROUPS`, 4: weight groups per run (≥1).
- `RD_LAT`, 2: read latency of the memory interfaces, from address present to data at output (≥1).
- `GRP_W`, `$clog2(N_GROUPS)` (minimum 1): width of `grp_idx`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: run request, sampled in IDLE only.
- `grp_ready`, input, 1: downstream accepts the group result.
- `busy`, output, 1: high in every state except IDLE.
- `w_load_en`, output, 1: advance the weight line pointer, one-cycle pulse.
- `in_load_en`, output, 1: advance the input pointer.
- `acc_clr`, output, 1: clear the MAC accumulators.
- `mac_en`, output, 1: MAC row accumulates the current operands.
- `grp_valid`, output, 1: group result valid in the MAC accumulators.
- `grp_idx`, output, GRP_W: index of the current group, 0..N_GROUPS-1.
- `done`, output, 1: one-cycle pulse when the run completes.

## Operation
- **States:** IDLE, WFILL, STREAM, DRAIN, NEXT, DONE.
- **IDLE**
  - `start`=1 → WFILL, with `grp_idx`=0.
  - `start` while in any other state is ignored.
- **WFILL**
  - Lasts RD_LAT cycles, so weight data settles after the pointer change.
  - `acc_clr`=1 on the last WFILL cycle only.
  - → STREAM.
- **STREAM**
  - Lasts exactly K_LEN cycles. `in_load_en`=1 on every STREAM cycle.
  - An issue bit of 1 enters an RD_LAT-deep shift register on each STREAM cycle; 0 enters otherwise.
  - `mac_en` is the shift register output, i.e. STREAM delayed by RD_LAT.
  - → DRAIN.
- **DRAIN**
  - Lasts RD_LAT cycles, which drains the issue pipe.
  - The shift register must be empty on exit.
  - → NEXT.
- **NEXT**
  - `grp_valid`=1, held until `grp_ready`=1.
  - On the transfer cycle (`grp_valid` & `grp_ready`), `w_load_en`=1 for that cycle only.
  - If `grp_idx`==N_GROUPS-1 → DONE; otherwise increment `grp_idx` → WFILL.
  - `grp_valid` holds at 1 and `grp_idx` holds constant while waiting.
- **DONE**
  - `done`=1 for one cycle → IDLE.
  - `grp_idx` returns to 0 on entering IDLE.
- **Counters**
  - Phase counter width: `$clog2(max(K_LEN,RD_LAT)+1)`.
  - The counter resets to 0 on every state entry.
  - No counter overflows for any legal parameter set.
- **Pointers**
  - The controller never resets the memory pointers.
  - One run consumes exactly N_GROUPS×K_LEN input addresses and N_GROUPS weight lines.
  - Back-to-back runs continue from the current pointers.
  - Pointer wrap is handled by the memory interfaces. Wrap needs no special behaviour here.
- **Reset**
  - `rst_n` low at any time, including mid-STREAM or mid-NEXT, forces IDLE immediately.
  - All outputs go to 0, `grp_idx`=0, and the shift register is cleared.
  - No `load_en` pulses are emitted during reset or in the cycle it deasserts.

## Timing
- Cycle 0 is the cycle in which `start` is sampled in IDLE. Per group, with `grp_ready` held high:
  - WFILL: cycles 1..RD_LAT; `acc_clr` is asserted at cycle RD_LAT.
  - STREAM: cycles RD_LAT+1..RD_LAT+K_LEN.
  - `mac_en`: cycles 2·RD_LAT+1..2·RD_LAT+K_LEN, i.e. K_LEN consecutive cycles.
  - DRAIN: cycles RD_LAT+K_LEN+1..2·RD_LAT+K_LEN.
  - NEXT: cycle 2·RD_LAT+K_LEN+1.
- Group period is 2·RD_LAT+K_LEN+1 cycles, plus any `grp_ready` wait cycles.
- `done` asserts at cycle N_GROUPS·(2·RD_LAT+K_LEN+1)+1. `busy` falls in the following cycle.
- The last `mac_en` cycle always precedes the first `grp_valid` cycle by exactly 1.
- `mac_en` and `acc_clr` are never high in the same cycle.
- `w_load_en` and `in_load_en` are never high in the same cycle.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs except `w_load_en` (`grp_ready` & NEXT).

## Test plan
- **Reset:** `rst_n`=0 for 3 cycles, then release → all outputs 0, `grp_idx`=0, IDLE held with `start`=0.
- **Single run, defaults, `grp_ready`=1:** `start` pulse →
  - 4 groups, 16 `in_load_en` and 16 `mac_en` cycles per group;
  - `mac_en` first high at cycle 5;
  - `grp_valid` at cycles 21/42/63/84 with `grp_idx` 0/1/2/3;
  - 4 `w_load_en` pulses; `done` at cycle 85.
- **Backpressure:** `grp_ready`=0 for 5 cycles at group 1 →
  - `grp_valid`=1 and `grp_idx`=1 held steady, no `w_load_en`, no `in_load_en`;
  - resumes on `grp_ready`=1; `done` at cycle 90.
- **Ignored start:** `start` held high through a whole run → exactly one run per IDLE visit. A second run begins at cycle 86, and input pointers continue at 64.
- **Mid-run reset:** `rst_n` low at the 7th STREAM cycle of group 2 → outputs 0 immediately, no further `load_en` pulses. A new `start` restarts with `grp_idx`=0.
- **Edge parameters:** K_LEN=1, N_GROUPS=1, RD_LAT=1 → one `in_load_en` and one `mac_en` (at cycle 3), `grp_valid` at cycle 4, `done` at cycle 5.
